// File: rtl/led_pkg.sv
// Shared types for the LED driver stages on the clk50 domain.
package led_pkg;

    localparam int PHASE_W = 3;

    // Breathing FSM states; the encodings are visible on the phase output.
    typedef enum logic [PHASE_W-1:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } phase_e;

endpackage

// File: rtl/led_breather_if.sv
// Control/status bundle between board logic (master) and the breather (slave).
// enable/pause are level controls with no handshake: the breather samples them
// on every clk50 edge. All status signals are registered in the breather.
interface led_breather_if #(
    parameter int PWM_BITS = 8
) ();
    import led_pkg::*;

    logic                enable;
    logic                pause;
    logic                led_pwm;
    logic [PWM_BITS-1:0] level;
    logic [PHASE_W-1:0]  phase;
    logic                cycle_done;

    modport master (
        output enable, pause,
        input  led_pwm, level, phase, cycle_done
    );

    modport slave (
        input  enable, pause,
        output led_pwm, level, phase, cycle_done
    );
endinterface

// File: rtl/led_breather_tick_prescaler.sv
// Divides clk50 into a one-cycle tick every TICK_DIV running cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 195312
) (
    input  logic clk50,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Strobe on the last count of each period; never while stopped.
    assign tick = run && (cnt_q == LAST);

    // Count 0..TICK_DIV-1 while running; clear has priority and holds at 0.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            if (cnt_q == LAST) cnt_q <= '0;
            else               cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/led_breather.sv
// PWM breathing LED driver: ramp up, hold, ramp down, hold, repeat.
module led_breather
    import led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int TICK_DIV   = 195312,
    parameter int HOLD_TICKS = 64
) (
    input  logic          clk50,
    input  logic          rst_n,
    led_breather_if.slave bus
);
    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam int HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS);

    phase_e              state_q;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_inc;
    logic [PWM_BITS-1:0] level_dec;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_inc;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                led_pwm_q;
    logic                cycle_done_q;
    logic                tick;

    assign level_inc = level_q + 1'b1;
    assign level_dec = level_q - 1'b1;
    assign hold_inc  = hold_q + 1'b1;

    // Pause freezes the ramp timebase only; dropping enable restarts it.
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk50 (clk50),
        .rst_n (rst_n),
        .run   (bus.enable && !bus.pause),
        .clr   (!bus.enable),
        .tick  (tick)
    );

    // Free-running PWM counter, held at 0 while disabled.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n)           pwm_cnt_q <= '0;
        else if (!bus.enable) pwm_cnt_q <= '0;
        else                  pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end

    // Registered comparator; full scale forces a solid-on output.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) led_pwm_q <= 1'b0;
        else        led_pwm_q <= bus.enable && ((pwm_cnt_q < level_q) || (level_q == MAX));
    end

    // Breathing FSM; progresses on tick only, enable low forces IDLE.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            level_q      <= '0;
            hold_q       <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            cycle_done_q <= 1'b0;
            if (!bus.enable) begin
                state_q <= IDLE;
                level_q <= '0;
                hold_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        level_q <= '0;
                        hold_q  <= '0;
                        state_q <= RAMP_UP;
                    end
                    RAMP_UP: if (tick) begin
                        level_q <= level_inc;
                        if (level_inc == MAX) begin
                            hold_q  <= '0;
                            state_q <= (HOLD_TICKS == 0) ? RAMP_DOWN : HOLD_HIGH;
                        end
                    end
                    HOLD_HIGH: if (tick) begin
                        if (hold_inc == HOLD_LAST) begin
                            hold_q  <= '0;
                            state_q <= RAMP_DOWN;
                        end else begin
                            hold_q <= hold_inc;
                        end
                    end
                    RAMP_DOWN: if (tick) begin
                        level_q <= level_dec;
                        if (level_dec == '0) begin
                            hold_q <= '0;
                            if (HOLD_TICKS == 0) begin
                                state_q      <= RAMP_UP;
                                cycle_done_q <= 1'b1;
                            end else begin
                                state_q <= HOLD_LOW;
                            end
                        end
                    end
                    HOLD_LOW: if (tick) begin
                        if (hold_inc == HOLD_LAST) begin
                            hold_q       <= '0;
                            state_q      <= RAMP_UP;
                            cycle_done_q <= 1'b1;
                        end else begin
                            hold_q <= hold_inc;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        level_q <= '0;
                        hold_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.led_pwm    = led_pwm_q;
    assign bus.level      = level_q;
    assign bus.phase      = state_q;
    assign bus.cycle_done = cycle_done_q;
endmodule

// File: tb/tb_led_breather.sv
// Directed bench for led_breather with PWM_BITS=3, TICK_DIV=2, HOLD_TICKS=2.
module tb_led_breather;
    logic clk50 = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    led_breather_if #(.PWM_BITS(3)) bus ();

    led_breather #(.PWM_BITS(3), .TICK_DIV(2), .HOLD_TICKS(2)) dut (
        .clk50 (clk50),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
            $error("assertion on %s", tag);
        end
    endtask

    // Hand-derived breath table. i = clk50 edges since enable rose (i >= 1).
    // One breath = 18 ticks = 36 cycles; level steps every 2 cycles.
    function automatic int exp_phase(input int i);
        int j = ((i - 1) % 36) + 1;
        if (j <= 13) return 1;
        if (j <= 17) return 2;
        if (j <= 31) return 3;
        if (j <= 35) return 4;
        return 1;
    endfunction

    function automatic int exp_level(input int i);
        int j = ((i - 1) % 36) + 1;
        if (j <= 13) return j / 2;
        if (j <= 17) return 7;
        if (j <= 31) return 7 - (j - 18) / 2;
        return 0;
    endfunction

    function automatic int exp_done(input int i);
        return (((i - 1) % 36) + 1 == 36) ? 1 : 0;
    endfunction

    // Check n consecutive cycles against the table, starting at edge index i0.
    task automatic run_check(input int i0, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk50);
            chk("run_level", bus.level, exp_level(i0 + k));
            chk("run_phase", bus.phase, exp_phase(i0 + k));
            chk("run_done", bus.cycle_done, exp_done(i0 + k));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_led"}, bus.led_pwm, 0);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_phase"}, bus.phase, 0);
        chk({tag, "_done"}, bus.cycle_done, 0);
    endtask

    initial begin
        int hi_win;
        int hi_tot;

        // Reset, then idle with enable low.
        bus.enable = 1'b0;
        bus.pause  = 1'b0;
        @(negedge clk50);
        chk_zero("reset");
        @(negedge clk50);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk50);
            chk_zero("idle");
        end

        // Enable: ramp, hold, ramp down, hold, two full breaths, stop at level 3.
        bus.enable = 1'b1;
        run_check(1, 78);

        // Pause at level 3: duty 3/8, state frozen for 50 cycles.
        bus.pause = 1'b1;
        hi_win = 0;
        hi_tot = 0;
        for (int p = 0; p < 50; p++) begin
            @(negedge clk50);
            chk("p3_level", bus.level, 3);
            chk("p3_phase", bus.phase, 1);
            chk("p3_done", bus.cycle_done, 0);
            if (p < 48) begin
                hi_win += int'(bus.led_pwm);
                hi_tot += int'(bus.led_pwm);
                if (p % 8 == 7) begin
                    chk("p3_window_duty", hi_win, 3);
                    hi_win = 0;
                end
            end
        end
        chk("p3_total_duty", hi_tot, 18);

        // Resume from the same point and run to the first HOLD_HIGH cycle.
        bus.pause = 1'b0;
        run_check(79, 8);

        // Pause at level 7: LED solidly on.
        bus.pause = 1'b1;
        for (int p = 0; p < 16; p++) begin
            @(negedge clk50);
            chk("p7_led", bus.led_pwm, 1);
            chk("p7_level", bus.level, 7);
            chk("p7_phase", bus.phase, 2);
        end
        bus.pause = 1'b0;
        run_check(87, 10);

        // Now level 4 in RAMP_DOWN; drop enable.
        chk("pre_drop_level", bus.level, 4);
        chk("pre_drop_phase", bus.phase, 3);
        bus.enable = 1'b0;
        @(negedge clk50);
        chk("drop_phase", bus.phase, 0);
        chk("drop_level", bus.level, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk50);
            chk_zero("disabled");
        end

        // Re-enable: the ramp restarts from 0, run into HOLD_HIGH.
        bus.enable = 1'b1;
        run_check(1, 16);
        chk("hold_led", bus.led_pwm, 1);

        // Asynchronous reset between edges, during HOLD_HIGH.
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk50);
        chk_zero("in_rst");
        rst_n = 1'b1;
        run_check(1, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
